// File: rtl/fighter_pkg.sv
// fighter_pkg: animation codes, sequencer states and frame constants for the fighter sprite path
package fighter_pkg;
   typedef enum logic {LOOP, ONESHOT} state_e;
   localparam int FRAMES_PER_ANIM = 4;
   localparam logic [1:0] LAST_FRAME = 2'(FRAMES_PER_ANIM - 1);
   localparam logic [3:0] ANIM_IDLE       = 4'd0;
   localparam logic [3:0] ANIM_WALK       = 4'd1;
   localparam logic [3:0] ANIM_HIT        = 4'd2;
   localparam logic [3:0] ANIM_JUMP       = 4'd3;
   localparam logic [3:0] ANIM_PUNCH_LOW  = 4'd4;
   localparam logic [3:0] ANIM_PUNCH_MID  = 4'd5;
   localparam logic [3:0] ANIM_KICK_HIGH  = 4'd6;
   localparam logic [3:0] ANIM_CROUCH     = 4'd7;
   localparam logic [3:0] ANIM_BLOCK_LOW  = 4'd8;
   localparam logic [3:0] ANIM_BLOCK_HIGH = 4'd9;
   function automatic logic is_attack(input logic [3:0] a);
      return a >= ANIM_PUNCH_LOW && a <= ANIM_KICK_HIGH;
   endfunction
endpackage

// File: rtl/anim_req_prio.sv
// anim_req_prio: resolves simultaneous player requests into one animation code
module anim_req_prio
   import fighter_pkg::*;
(
   input  logic       move_left_i,
   input  logic       move_right_i,
   input  logic       crouch_i,
   input  logic       block_i,
   input  logic       jump_i,
   input  logic       punch_low_i,
   input  logic       punch_mid_i,
   input  logic       kick_high_i,
   input  logic       got_hit_i,
   output logic [3:0] anim_o,
   output logic       oneshot_o
);
   assign anim_o = got_hit_i   ? ANIM_HIT :
                   kick_high_i ? ANIM_KICK_HIGH :
                   punch_mid_i ? ANIM_PUNCH_MID :
                   punch_low_i ? ANIM_PUNCH_LOW :
                   jump_i      ? ANIM_JUMP :
                   block_i     ? (crouch_i ? ANIM_BLOCK_LOW : ANIM_BLOCK_HIGH) :
                   crouch_i    ? ANIM_CROUCH :
                   (move_left_i ^ move_right_i) ? ANIM_WALK : ANIM_IDLE;
   assign oneshot_o = anim_o >= ANIM_HIT && anim_o <= ANIM_KICK_HIGH;
endmodule

// File: rtl/fighter_anim_ctrl.sv
// fighter_anim_ctrl: frame-tick driven animation sequencer feeding the moving-sprite memory
module fighter_anim_ctrl
   import fighter_pkg::*;
#(
   parameter int TICKS_PER_FRAME = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       crouch,
   input  logic       block,
   input  logic       jump,
   input  logic       punch_low,
   input  logic       punch_mid,
   input  logic       kick_high,
   input  logic       got_hit,
   input  logic       facing_left,
   output logic [3:0] selanim,
   output logic [1:0] selframe,
   output logic       mirror,
   output logic       busy,
   output logic       hit_window,
   output logic       anim_done
);
   state_e     state_q, state_d;
   logic [3:0] anim_q, anim_d, tick_q, tick_d, req_anim;
   logic [1:0] frame_q, frame_d;
   logic       mirror_q, mirror_d, busy_q, busy_d, hitw_q, hitw_d, done_q, done_d;
   logic       req_oneshot, tick_last;
   logic [3:0] tick_nxt;
   anim_req_prio u_prio (
      .move_left_i (move_left),
      .move_right_i(move_right),
      .crouch_i    (crouch),
      .block_i     (block),
      .jump_i      (jump),
      .punch_low_i (punch_low),
      .punch_mid_i (punch_mid),
      .kick_high_i (kick_high),
      .got_hit_i   (got_hit),
      .anim_o      (req_anim),
      .oneshot_o   (req_oneshot)
   );
   assign tick_last = tick_q == 4'(TICKS_PER_FRAME - 1);
   assign tick_nxt  = tick_last ? 4'd0 : tick_q + 4'd1;
   always_comb begin
      state_d  = state_q;
      anim_d   = anim_q;
      frame_d  = frame_q;
      tick_d   = tick_q;
      mirror_d = mirror_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (frame_tick) begin
         if (state_q == LOOP) begin
            mirror_d = facing_left;
            if (req_anim != anim_q) begin
               anim_d  = req_anim;
               frame_d = 2'd0;
               tick_d  = 4'd0;
               state_d = req_oneshot ? ONESHOT : LOOP;
               busy_d  = req_oneshot;
            end else begin
               tick_d  = tick_nxt;
               // only idle and walk cycle frames; single-frame poses stay at 0
               frame_d = (tick_last && anim_q <= ANIM_WALK) ? frame_q + 2'd1 : frame_q;
            end
         end else if (got_hit) begin
            anim_d  = ANIM_HIT;
            frame_d = 2'd0;
            tick_d  = 4'd0;
         end else if (tick_last && frame_q == LAST_FRAME) begin
            state_d = LOOP;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            anim_d  = ANIM_IDLE;
            frame_d = 2'd0;
            tick_d  = 4'd0;
         end else begin
            tick_d  = tick_nxt;
            frame_d = tick_last ? frame_q + 2'd1 : frame_q;
         end
      end
      hitw_d = is_attack(anim_d) && frame_d == 2'd2;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= LOOP;
         anim_q   <= ANIM_IDLE;
         frame_q  <= 2'd0;
         tick_q   <= 4'd0;
         mirror_q <= 1'b0;
         busy_q   <= 1'b0;
         hitw_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         anim_q   <= anim_d;
         frame_q  <= frame_d;
         tick_q   <= tick_d;
         mirror_q <= mirror_d;
         busy_q   <= busy_d;
         hitw_q   <= hitw_d;
         done_q   <= done_d;
      end
   end
   assign selanim    = anim_q;
   assign selframe   = frame_q;
   assign mirror     = mirror_q;
   assign busy       = busy_q;
   assign hit_window = hitw_q;
   assign anim_done  = done_q;
endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// tb_fighter_anim_ctrl: scoreboard bench with a frame-count reference model of the sequencer
module tb_fighter_anim_ctrl;
   localparam int TPF = 2;
   logic clock = 0, reset = 1, frame_tick = 0;
   logic ml = 0, mr = 0, cr = 0, bl = 0, jp = 0, pl = 0, pm = 0, kh = 0, gh = 0, fl = 0;
   logic [3:0] selanim;
   logic [1:0] selframe;
   logic       mirror, busy, hit_window, anim_done;
   logic [9:0] act, last_exp = '0;
   logic [9:0] exp_q[$];
   int n_tests = 0, n_fail = 0;
   bit mon_en = 0;
   int m_anim = 0, m_elapsed = 0;
   bit m_mirror = 0;

   always #5 clock = ~clock;

   fighter_anim_ctrl #(.TICKS_PER_FRAME(TPF)) dut (
      .clock(clock), .reset(reset), .frame_tick(frame_tick),
      .move_left(ml), .move_right(mr), .crouch(cr), .block(bl), .jump(jp),
      .punch_low(pl), .punch_mid(pm), .kick_high(kh), .got_hit(gh), .facing_left(fl),
      .selanim(selanim), .selframe(selframe), .mirror(mirror), .busy(busy),
      .hit_window(hit_window), .anim_done(anim_done)
   );
   assign act = {selanim, selframe, mirror, busy, hit_window, anim_done};

   // request bit order: 0 ml,1 mr,2 crouch,3 block,4 jump,5 plow,6 pmid,7 khigh,8 hit,9 facing
   function automatic int resolve(input logic [9:0] r);
      if (r[8]) return 2;
      if (r[7]) return 6;
      if (r[6]) return 5;
      if (r[5]) return 4;
      if (r[4]) return 3;
      if (r[3]) return r[2] ? 8 : 9;
      if (r[2]) return 7;
      if (r[0] != r[1]) return 1;
      return 0;
   endfunction

   function automatic logic [9:0] expect_vec(input bit done);
      int frame;
      bit oneshot, attack;
      frame   = (m_anim >= 7) ? 0 : (m_elapsed / TPF) % 4;
      oneshot = m_anim >= 2 && m_anim <= 6;
      attack  = m_anim >= 4 && m_anim <= 6;
      return {4'(m_anim), 2'(frame), m_mirror, oneshot, attack && frame == 2, done};
   endfunction

   task automatic tick(input logic [9:0] r, input int gap);
      bit done;
      @(negedge clock);
      {fl, gh, kh, pm, pl, jp, bl, cr, mr, ml} = r;
      frame_tick = 1;
      done = 0;
      if (m_anim >= 2 && m_anim <= 6) begin
         if (r[8]) begin
            m_anim = 2;
            m_elapsed = 0;
         end else begin
            m_elapsed++;
            if (m_elapsed == 4 * TPF) begin
               m_anim = 0;
               m_elapsed = 0;
               done = 1;
            end
         end
      end else begin
         m_mirror = r[9];
         if (resolve(r) != m_anim) begin
            m_anim = resolve(r);
            m_elapsed = 0;
         end else m_elapsed++;
      end
      exp_q.push_back(expect_vec(done));
      @(negedge clock);
      frame_tick = 0;
      {fl, gh, kh, pm, pl, jp, bl, cr, mr, ml} = 10'($urandom);
      repeat (gap) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1;
      mon_en = 1;
      m_anim = 0;
      m_elapsed = 0;
      m_mirror = 0;
      exp_q.push_back('0);
      @(negedge clock);
      reset = 0;
   endtask

   always @(posedge clock) begin
      if (mon_en) begin
         bit sampled;
         logic [9:0] e;
         sampled = reset | frame_tick;
         #1;
         n_tests++;
         if (sampled) begin
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL update: no expected entry, act=%b", act);
            end else begin
               e = exp_q.pop_front();
               last_exp = e;
               if (act !== e) begin
                  n_fail++;
                  $display("FAIL update: act={anim,frame,mir,busy,hw,done}=%b exp=%b", act, e);
               end
            end
         end else begin
            e = {last_exp[9:1], 1'b0};
            last_exp = e;
            if (act !== e) begin
               n_fail++;
               $display("FAIL hold: act=%b exp=%b", act, e);
            end
         end
      end
   end

   initial begin
      repeat (2) @(negedge clock);
      reset = 0;
      do_reset();
      repeat (9) tick(10'h000, 3);
      tick(10'h040, 3);
      repeat (10) tick(10'h000, 3);
      tick(10'h080, 3);
      repeat (2) tick(10'h000, 3);
      tick(10'h088, 3);
      tick(10'h100, 3);
      repeat (9) tick(10'h000, 3);
      repeat (3) tick(10'h003, 3);
      repeat (3) tick(10'h00C, 3);
      repeat (10) tick(10'h008, 3);
      tick(10'h010, 3);
      for (int i = 0; i < 8; i++) tick((i % 2) ? 10'h200 : 10'h000, 3);
      repeat (2) tick(10'h200, 3);
      tick(10'h020, 3);
      repeat (4) tick(10'h000, 3);
      do_reset();
      tick(10'h040, 3);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 50) == 0) do_reset();
         tick(10'($urandom & $urandom & $urandom) | {$urandom_range(0, 1) == 1, 9'h0}, $urandom_range(0, 3));
      end
      repeat (3) @(negedge clock);
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d updates never observed, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fighter_anim_ctrl.md
Name: fighter_anim_ctrl

Overview:
Per-fighter animation sequencer that sits directly upstream of the moving-sprite memory.
- Turns player action requests and a once-per-video-frame tick into the `selanim`/`selframe`/`mirror` selectors the sprite memory consumes.
- Enforces action priority and one-shot (non-interruptible) attack, jump and hit sequences.
- Exposes attack hit-window and completion status to game logic.

Parameters:
TICKS_PER_FRAME, 6, frame_tick pulses per animation frame (legal range 1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
move_left  in  1  walk-left request (level)
move_right  in  1  walk-right request (level)
crouch  in  1  crouch request (level)
block  in  1  block request (level)
jump  in  1  jump request (level)
punch_low  in  1  low-punch request (level)
punch_mid  in  1  mid-punch request (level)
kick_high  in  1  high-kick request (level)
got_hit  in  1  hit-received (level)
facing_left  in  1  desired facing direction
selanim  out  4  animation code to sprite memory
selframe  out  2  frame index to sprite memory
mirror  out  1  horizontal flip to sprite memory
busy  out  1  one-shot sequence in progress
hit_window  out  1  attack in its damaging frame
anim_done  out  1  one-cycle pulse at one-shot completion

Behaviour:
- Animation codes are fixed:
  - Four-frame: 0 idle, 1 walk, 2 hit, 3 jump, 4 low punch, 5 mid punch, 6 high kick.
  - Single-frame: 7 crouch, 8 block low, 9 block high.
- All outputs are registered. Reset values: `selanim`=0, `selframe`=0, `mirror`=0, `busy`=0, `hit_window`=0, `anim_done`=0, `tick_cnt`=0, state=LOOP.
- Reset mid-sequence aborts immediately to those values.
- Inputs are evaluated only on cycles where `frame_tick`=1. Outputs change on the following clock edge (1-cycle latency) and are otherwise held.
- States:
  - LOOP: codes 0, 1, 7, 8, 9.
  - ONESHOT: codes 2 to 6.
- Request resolution in LOOP on a tick, highest priority first:
  - `got_hit` → 2
  - `kick_high` → 6
  - `punch_mid` → 5
  - `punch_low` → 4
  - `jump` → 3
  - `block` → 8 if `crouch`, else 9
  - `crouch` → 7
  - exactly one of `move_left`/`move_right` → 1
  - otherwise (including both held) → 0
- Code change on a tick:
  - `selframe`←0 and `tick_cnt`←0.
  - Codes 2 to 6 enter ONESHOT and set `busy`=1.
- Same code on a tick:
  - `tick_cnt` increments.
  - When `tick_cnt`=TICKS_PER_FRAME-1, it wraps to 0 and `selframe` advances.
  - `selframe` wraps 3→0 for codes 0/1 and stays 0 for codes 7/8/9.
- ONESHOT advances `tick_cnt`/`selframe` identically, with these rules:
  - All requests are ignored except `got_hit`.
  - `got_hit` on a tick restarts code 2 at frame 0, including when already in hit.
  - When frame 3 completes: state←LOOP, `busy`←0, `anim_done` pulses for exactly one cycle, and code←0 with frame 0.
  - Requests are next resolved on the following tick (no same-tick chaining).
- `mirror` updates from `facing_left` on ticks while in LOOP. It is frozen for the whole of ONESHOT.
- `hit_window`=1 iff `selanim` is 4, 5 or 6 and `selframe`=2.
- `tick_cnt` is 4 bits. With TICKS_PER_FRAME=1 every tick advances the frame.

Decomposition:
- Shared package (`fighter_pkg`):
  - Animation code constants ANIM_IDLE…ANIM_BLOCK_HIGH (0 to 9).
  - State encoding (LOOP, ONESHOT).
  - FRAMES_PER_ANIM=4.
- Sub-module `anim_req_prio`: combinational priority resolver. It maps the request inputs to the next animation code and an is_oneshot flag. The FSM and counters stay in `fighter_anim_ctrl`.

Test Plan:
- Reset, then idle with `frame_tick` every 4 cycles and TICKS_PER_FRAME=2 → `selanim`=0 and `selframe` steps 0,0,1,1,2,2,3,3,0.
- `punch_mid` held for 1 tick → `selanim`=5, `busy`=1; `hit_window`=1 only during frame 2; after 8 ticks `anim_done` is a single-cycle pulse, then `selanim`=0.
- During high kick (code 6) at frame 1, assert `kick_high`+`block` → no change; assert `got_hit` → `selanim`=2, `selframe`=0 on the next cycle.
- `move_left` and `move_right` both held → `selanim`=0; `block`+`crouch` → 8; `block` alone → 9 with `selframe` fixed at 0 over 10 ticks.
- Toggle `facing_left` during jump (code 3) → `mirror` unchanged until `anim_done`, then follows on the next LOOP tick.
- Assert `reset` at frame 2 of low punch (code 4) → next cycle all outputs 0 and LOOP; a request on the next tick is honoured normally.
